// File: rtl/reset_sequencer.sv
// Clocked reset sequencer: releases reset outputs, then start outputs, and samples a delay level,
// with software-requested re-sequencing and an asynchronous active-low reset.
module reset_sequencer #(
  parameter int RESETS       = 1,
  parameter int STARTS       = 0,
  parameter int DELAYS       = 0,
  parameter int RESET_CYCLES = 10,
  parameter int START_CYCLES = 10,
  parameter int CNT_W        = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             cfg_dly,
  input  logic                             req_restart,
  output logic [RESETS+STARTS+DELAYS-1:0]  out_n,
  output logic                             busy,
  output logic                             done
);

  typedef enum logic [1:0] {ST_RST, ST_STRT, ST_RUN} state_t;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STRT_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_q, rst_d;
  logic             strt_q, strt_d;
  logic             dly_q, dly_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    strt_d  = strt_q;
    dly_d   = dly_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (req_restart) begin
      // Restart wins over every transition and clears all groups, delay bits included.
      state_d = ST_RST;
      cnt_d   = '0;
      rst_d   = 1'b0;
      strt_d  = 1'b0;
      dly_d   = 1'b0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_RST: begin
          if (cnt_q == '0) dly_d = cfg_dly;
          if (cnt_q == RST_LAST) begin
            rst_d = 1'b1;
            cnt_d = '0;
            if (STARTS > 0) begin
              state_d = ST_STRT;
            end else begin
              state_d = ST_RUN;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_STRT: begin
          if (cnt_q == STRT_LAST) begin
            strt_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_RUN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      rst_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Start and delay groups only get storage when they exist.
  generate
    if (STARTS > 0) begin : g_strt
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) strt_q <= 1'b0;
        else          strt_q <= strt_d;
      end
      assign out_n[RESETS+STARTS-1:RESETS] = {STARTS{strt_q}};
    end else begin : g_no_strt
      logic unused_strt;
      assign strt_q      = 1'b0;
      assign unused_strt = strt_d;
    end

    if (DELAYS > 0) begin : g_dly
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dly_q <= 1'b0;
        else          dly_q <= dly_d;
      end
      assign out_n[RESETS+STARTS+DELAYS-1:RESETS+STARTS] = {DELAYS{dly_q}};
    end else begin : g_no_dly
      logic unused_dly;
      assign dly_q      = 1'b0;
      assign unused_dly = dly_d ^ cfg_dly;
    end
  endgenerate

  assign out_n[RESETS-1:0] = {RESETS{rst_q}};
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a 2/1/1 instance with default hold counts and a
// single-reset instance with RESET_CYCLES=1 and no start or delay group.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cfg_dly;
  logic       req_a;
  logic       req_b;
  logic [3:0] out_a;
  logic [0:0] out_b;
  logic       busy_a, done_a, busy_b, done_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .RESETS(2), .STARTS(1), .DELAYS(1), .RESET_CYCLES(10), .START_CYCLES(10), .CNT_W(16)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .cfg_dly(cfg_dly), .req_restart(req_a),
    .out_n(out_a), .busy(busy_a), .done(done_a)
  );

  reset_sequencer #(
    .RESETS(1), .STARTS(0), .DELAYS(0), .RESET_CYCLES(1), .START_CYCLES(10), .CNT_W(4)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .cfg_dly(cfg_dly), .req_restart(req_b),
    .out_n(out_b), .busy(busy_b), .done(done_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cfg_dly = 1'b1; req_a = 1'b0; req_b = 1'b0;
    repeat (3) tick();
    n_chk++; if (out_a !== 4'b0000) begin n_fail++; $display("FAIL reset out_a: got %b expected 0000", out_a); end
    n_chk++; if (busy_a !== 1'b1 || done_a !== 1'b0) begin n_fail++; $display("FAIL reset flags_a: busy %b done %b expected 1 0", busy_a, done_a); end
    n_chk++; if (out_b !== 1'b0 || busy_b !== 1'b1 || done_b !== 1'b0) begin n_fail++; $display("FAIL reset dut_b: out %b busy %b done %b expected 0 1 0", out_b, busy_b, done_b); end
    reset_n = 1'b1;
  endtask

  task automatic test_power_up();
    logic [3:0] exp;
    for (int e = 1; e <= 20; e++) begin
      tick();
      exp = {1'b1, (e >= 20), (e >= 10) ? 2'b11 : 2'b00};
      n_chk++; if (out_a !== exp) begin n_fail++; $display("FAIL power_up out_a edge %0d: got %b expected %b", e, out_a, exp); end
      n_chk++; if (busy_a !== (e < 20) || done_a !== (e >= 20)) begin n_fail++; $display("FAIL power_up flags edge %0d: busy %b done %b", e, busy_a, done_a); end
      n_chk++; if (out_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b1) begin n_fail++; $display("FAIL rc1 edge %0d: out %b busy %b done %b expected 1 0 1", e, out_b, busy_b, done_b); end
    end
  endtask

  task automatic test_restart_run();
    logic [3:0] exp;
    cfg_dly = 1'b0;
    req_a = 1'b1;
    tick();
    req_a = 1'b0;
    n_chk++; if (out_a !== 4'b0000 || busy_a !== 1'b1 || done_a !== 1'b0) begin n_fail++; $display("FAIL restart_run clear: out %b busy %b done %b", out_a, busy_a, done_a); end
    for (int e = 1; e <= 20; e++) begin
      tick();
      exp = {1'b0, (e >= 20), (e >= 10) ? 2'b11 : 2'b00};
      n_chk++; if (out_a !== exp) begin n_fail++; $display("FAIL restart_run out_a edge %0d: got %b expected %b", e, out_a, exp); end
      n_chk++; if (done_a !== (e >= 20)) begin n_fail++; $display("FAIL restart_run done edge %0d: got %b", e, done_a); end
    end
    repeat (3) begin
      tick();
      n_chk++; if (out_a !== 4'b0111 || done_a !== 1'b1 || busy_a !== 1'b0) begin n_fail++; $display("FAIL restart_run hold: out %b done %b busy %b", out_a, done_a, busy_a); end
    end
  endtask

  task automatic test_restart_strt();
    logic [3:0] exp;
    req_a = 1'b1;
    tick();
    req_a = 1'b0;
    repeat (15) tick();
    n_chk++; if (out_a !== 4'b0011) begin n_fail++; $display("FAIL restart_strt pre: got %b expected 0011", out_a); end
    // Held for three edges: stays cleared, counting starts after the drop.
    req_a = 1'b1;
    repeat (3) begin
      tick();
      n_chk++; if (out_a !== 4'b0000 || busy_a !== 1'b1) begin n_fail++; $display("FAIL restart_strt clear: out %b busy %b", out_a, busy_a); end
    end
    req_a = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      exp = {1'b0, (e >= 20), (e >= 10) ? 2'b11 : 2'b00};
      n_chk++; if (out_a !== exp) begin n_fail++; $display("FAIL restart_strt out_a edge %0d: got %b expected %b", e, out_a, exp); end
    end
  endtask

  task automatic test_cfg_toggle();
    logic [3:0] exp;
    logic [7:0] ev;
    cfg_dly = 1'b1;
    req_a = 1'b1;
    tick();
    req_a = 1'b0;
    tick();
    n_chk++; if (out_a !== 4'b1000) begin n_fail++; $display("FAIL cfg_toggle load: got %b expected 1000", out_a); end
    for (int e = 2; e <= 26; e++) begin
      ev = 8'(e);
      cfg_dly = ev[0];
      tick();
      exp = {1'b1, (e >= 20), (e >= 10) ? 2'b11 : 2'b00};
      n_chk++; if (out_a !== exp) begin n_fail++; $display("FAIL cfg_toggle edge %0d: got %b expected %b", e, out_a, exp); end
    end
  endtask

  task automatic test_async_reset();
    cfg_dly = 1'b1;
    req_a = 1'b1;
    tick();
    req_a = 1'b0;
    repeat (12) tick();
    n_chk++; if (out_a !== 4'b1011) begin n_fail++; $display("FAIL async pre: got %b expected 1011", out_a); end
    #3;
    reset_n = 1'b0;
    #1;
    n_chk++; if (out_a !== 4'b0000 || busy_a !== 1'b1 || done_a !== 1'b0) begin n_fail++; $display("FAIL async dut_a: out %b busy %b done %b", out_a, busy_a, done_a); end
    n_chk++; if (out_b !== 1'b0 || busy_b !== 1'b1 || done_b !== 1'b0) begin n_fail++; $display("FAIL async dut_b: out %b busy %b done %b", out_b, busy_b, done_b); end
    reset_n = 1'b1;
    tick();
    n_chk++; if (out_a !== 4'b1000) begin n_fail++; $display("FAIL async restart_a: got %b expected 1000", out_a); end
    n_chk++; if (out_b !== 1'b1 || done_b !== 1'b1) begin n_fail++; $display("FAIL async restart_b: out %b done %b", out_b, done_b); end
  endtask

  task automatic test_rc1_restart();
    req_b = 1'b1;
    repeat (2) begin
      tick();
      n_chk++; if (out_b !== 1'b0 || busy_b !== 1'b1 || done_b !== 1'b0) begin n_fail++; $display("FAIL rc1_restart held: out %b busy %b done %b", out_b, busy_b, done_b); end
    end
    req_b = 1'b0;
    tick();
    n_chk++; if (out_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b1) begin n_fail++; $display("FAIL rc1_restart release: out %b busy %b done %b", out_b, busy_b, done_b); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_restart_run();
    test_restart_strt();
    test_cfg_toggle();
    test_async_reset();
    test_rc1_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Synthesizable, clocked replacement for the behavioural reset generator used by csp2verilog simulation benches.
- Drives three ordered groups of active-low outputs: RESETS, then STARTS, then DELAYS.
- Reset group releases after a programmable hold; start group releases after a second hold; delay group carries a sampled configuration level.
- Supports software-requested re-sequencing, so a single elaborated design can be reset repeatedly without a global reset.

Parameters:
- RESETS, 1, number of reset outputs (must be >= 1).
- STARTS, 0, number of start outputs (0 = no start phase).
- DELAYS, 0, number of delay-select outputs (0 = none).
- RESET_CYCLES, 10, clock cycles reset group is held low (must be >= 1).
- START_CYCLES, 10, cycles between reset release and start release (must be >= 1).
- CNT_W, 16, counter width; must satisfy 2^CNT_W > max(RESET_CYCLES, START_CYCLES).

Ports:
- clk  input  1  sequencer clock.
- reset_n  input  1  asynchronous, active-low reset.
- cfg_dly  input  1  delay level, replicated onto every delay output when sampled.
- req_restart  input  1  synchronous re-sequence request, sampled each rising edge.
- out_n  output  RESETS+STARTS+DELAYS  bit layout:
  - [RESETS-1:0] = resets
  - [RESETS+STARTS-1:RESETS] = starts
  - upper DELAYS bits = delays
- busy  output  1  high while sequencing (state != RUN).
- done  output  1  high in RUN; all reset and start outputs released.

Behaviour:
- Reset values while reset_n low: out_n = all 0; busy = 1; done = 0; state = RST; cnt = 0. All outputs are registered.
- States: RST, STRT, RUN.
- RST, each rising edge:
  - if cnt == 0, load every delay bit with cfg_dly.
  - if cnt == RESET_CYCLES-1: set reset bits to 1 and clear cnt. Go to STRT if STARTS > 0. Otherwise go to RUN, with done = 1 and busy = 0 on the same edge.
  - else cnt++.
- Timing: reset bits rise on the RESET_CYCLES-th rising edge after reset_n deasserts (edge 1 = first edge with reset_n high).
- STRT, each rising edge:
  - if cnt == START_CYCLES-1: set start bits to 1, cnt = 0, go to RUN, done = 1, busy = 0.
  - else cnt++.
- RUN: hold all outputs; cnt stays 0.
- req_restart = 1 on an edge, in any state, overrides all other transitions:
  - next out_n = all 0 (delay bits included); state = RST; cnt = 0; done = 0; busy = 1.
  - delay bits reload from cfg_dly on the following edge (cnt == 0 in RST).
- Restart held high for N cycles keeps the block in RST with cnt = 0. Counting begins on the first edge after req_restart drops.
- Restart during RST or STRT abandons the current count. Reset bits already released drop back to 0.
- cfg_dly changes outside the cnt == 0 RST edge have no effect on outputs.
- Asynchronous reset_n assertion at any time immediately forces reset values, independent of clk.
- RESET_CYCLES == 1: reset bits rise on edge 1; delay load and release happen on the same edge.
- DELAYS == 0 or STARTS == 0: the corresponding out_n slices do not exist; no logic is generated for them.
- Counter never wraps: compare-and-clear occurs before overflow under the CNT_W constraint.

Test Plan:
- RESETS=2, STARTS=1, DELAYS=1, defaults; cfg_dly=1; release reset_n:
  - out_n[3] = 1 after edge 1.
  - out_n[1:0] = 2'b11 after edge 10.
  - out_n[2] = 1 after edge 20; done = 1 and busy = 0 from edge 20.
- STARTS=0, RESET_CYCLES=1: reset_n released -> out_n[0] = 1 and done = 1 after edge 1; busy never high after edge 1.
- In RUN, pulse req_restart for one cycle with cfg_dly=0:
  - out_n = 0 next edge; delay bit stays 0.
  - reset bits rise 10 edges after the restart-low edge; start bits rise 10 edges after that.
- req_restart at STRT cnt=5:
  - reset bits drop to 0 next edge; full 10+10 sequence repeats.
  - start bits never go high early.
- Assert reset_n asynchronously mid-STRT (between clock edges) -> out_n = 0, done = 0 and busy = 1 immediately, without a clock edge.
- Toggle cfg_dly during RST cnt=3..9 and in RUN -> delay bits keep the value sampled at cnt=0.
